// File: rtl/sim_mem_port.sv
// Simulation memory port: one request at a time, fixed response latency,
// byte-lane writes, and an error response for addresses outside the store window.
module sim_mem_port #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                DEPTH_LOG2 = 12,
  parameter int                LATENCY    = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(32'h8000_0000)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int NBYTES   = DATA_W / 8;
  localparam int OFF_BITS = $clog2(NBYTES);
  localparam int DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [NBYTES-1:0]   r_wmask;
  logic                r_respValid;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_accept;
  logic                w_enterResp;
  logic                w_curWe;
  logic [ADDR_W-1:0]   w_curAddr;
  logic [DATA_W-1:0]   w_curWdata;
  logic [NBYTES-1:0]   w_curWmask;
  logic [ADDR_W-1:0]   w_off;
  logic [ADDR_W-1:0]   w_wordIdx;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                w_outOfRange;
  logic [DATA_W-1:0]   w_rdData;

  assign req_ready  = (r_state == IDLE) && !rst;
  assign resp_valid = r_respValid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  assign w_accept = req_valid && req_ready;

  // With zero latency the store is touched on the accept edge itself, so the
  // live request fields are used; otherwise the latched copy is.
  assign w_curWe    = (r_state == IDLE) ? req_we    : r_we;
  assign w_curAddr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_curWdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_curWmask = (r_state == IDLE) ? req_wmask : r_wmask;

  assign w_enterResp = !rst &&
                       ((w_accept && (LATENCY == 0)) ||
                        ((r_state == WAIT) && (r_cnt == 4'd0)));

  // Below-base check is separate so the unsigned subtraction cannot wrap into range.
  assign w_off        = w_curAddr - BASE_ADDR;
  assign w_wordIdx    = w_off >> OFF_BITS;
  assign w_idx        = w_wordIdx[DEPTH_LOG2-1:0];
  assign w_outOfRange = (w_curAddr < BASE_ADDR) || ((w_wordIdx >> DEPTH_LOG2) != '0);

  assign w_rdData = (w_curWe || w_outOfRange) ? '0 : r_mem[w_idx];

  always_ff @(posedge clk) begin
    if (w_enterResp && w_curWe && !w_outOfRange) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (w_curWmask[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_curWdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_respValid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wmask <= req_wmask;
            if (LATENCY == 0) begin
              r_state     <= RESP;
              r_respValid <= 1'b1;
              r_rdata     <= w_rdData;
              r_err       <= w_outOfRange;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= RESP;
            r_respValid <= 1'b1;
            r_rdata     <= w_rdData;
            r_err       <= w_outOfRange;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state     <= IDLE;
            r_respValid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_respValid <= 1'b0;
        end
      endcase
    end
  end

endmodule
